// File: rtl/order_ingress_sequencer.sv
// rtl/order_ingress_sequencer.sv - FIFO-buffered ingress that issues orders/max updates to the risk stage one at a time
module order_ingress_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     HRESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_client_id,
    input  logic [15:0]              in_amount,
    input  logic                     in_is_max,
    output logic [4:0]               client_id,
    output logic [15:0]              amount,
    output logic                     new_order,
    output logic                     new_max,
    input  logic                     risk_done,
    input  logic                     risk_ok,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         accept_cnt,
    output logic [CNT_W-1:0]         reject_cnt,
    output logic [CNT_W-1:0]         timeout_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t          state;
    logic [21:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [7:0]      timer;
    logic            cur_is_max;
    logic            push;
    logic            pop;
    logic [21:0]     head;

    // No bypass: readiness follows the registered occupancy only.
    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = (state == ST_WAIT) && (risk_done || timer == TIMER_LAST);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_is_max, in_client_id, in_amount};
        end
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            client_id   <= '0;
            amount      <= '0;
            new_order   <= 1'b0;
            new_max     <= 1'b0;
            cur_is_max  <= 1'b0;
            timer       <= '0;
            accept_cnt  <= '0;
            reject_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            new_order <= 1'b0;
            new_max   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        cur_is_max <= head[21];
                        client_id  <= head[20:16];
                        amount     <= head[15:0];
                        new_order  <= !head[21];
                        new_max    <= head[21];
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done on the last allowed cycle wins over the timeout.
                    if (risk_done) begin
                        if (!cur_is_max) begin
                            if (risk_ok) begin
                                if (accept_cnt != '1) accept_cnt <= accept_cnt + CNT_W'(1);
                            end else begin
                                if (reject_cnt != '1) reject_cnt <= reject_cnt + CNT_W'(1);
                            end
                        end
                        state <= ST_IDLE;
                    end else if (timer == TIMER_LAST) begin
                        if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_order_ingress_sequencer.sv
// tb/tb_order_ingress_sequencer.sv - scoreboard bench for order_ingress_sequencer
module tb_order_ingress_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 16;

    logic        clk = 1'b0;
    logic        HRESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_client_id = '0;
    logic [15:0] in_amount = '0;
    logic        in_is_max = 1'b0;
    logic [4:0]  client_id;
    logic [15:0] amount;
    logic        new_order;
    logic        new_max;
    logic        risk_done;
    logic        risk_ok;
    logic        busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] reject_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    logic        auto_done = 1'b0;
    logic        man_done = 1'b0;
    logic        resp_ok = 1'b1;
    int          resp_delay = 0;
    int          wcnt = 0;
    bit          active = 1'b0;
    int          last_wait = 0;
    bit          mon_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          n_order = 0;
    int          n_max = 0;
    logic [21:0] exp_q [$];
    logic [20:0] cur_exp = '0;

    assign risk_done = auto_done | man_done;
    assign risk_ok   = resp_ok;

    order_ingress_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .HRESET(HRESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_client_id(in_client_id), .in_amount(in_amount), .in_is_max(in_is_max),
        .client_id(client_id), .amount(amount),
        .new_order(new_order), .new_max(new_max),
        .risk_done(risk_done), .risk_ok(risk_ok),
        .busy(busy), .fifo_count(fifo_count),
        .accept_cnt(accept_cnt), .reject_cnt(reject_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every issue pulse must match the oldest accepted request.
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (new_order === 1'b1 || new_max === 1'b1) begin
                    if (new_order === 1'b1) n_order++;
                    if (new_max === 1'b1) n_max++;
                    check("pulse_onehot", 32'(new_order ^ new_max), 32'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_issue: got id=%0d amt=%0d expected no issue", client_id, amount);
                    end else begin
                        e = exp_q.pop_front();
                        cur_exp = e[20:0];
                        check("issue_order", 32'({new_max, client_id, amount}), 32'(e));
                    end
                end else if (busy === 1'b1) begin
                    check("hold_stable", 32'({client_id, amount}), 32'(cur_exp));
                end
            end
        end
    end

    // Risk-stage model: answers on WAIT cycle resp_delay (0 = never answer).
    initial begin
        forever begin
            @(negedge clk);
            if (new_order === 1'b1 || new_max === 1'b1) begin
                wcnt = 0;
                active = 1'b1;
                auto_done = 1'b0;
            end else if (active && busy === 1'b1) begin
                wcnt++;
                if (resp_delay != 0 && wcnt == resp_delay) begin
                    auto_done = 1'b1;
                    active = 1'b0;
                    last_wait = wcnt;
                end else begin
                    auto_done = 1'b0;
                end
            end else begin
                if (active) last_wait = wcnt;
                active = 1'b0;
                auto_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_req(input logic [4:0] id, input logic [15:0] amt, input logic mx, output int waits);
        in_valid = 1'b1;
        in_client_id = id;
        in_amount = amt;
        in_is_max = mx;
        waits = 0;
        while (in_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_stall: in_ready=%0b expected 1 within 200 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back({mx, id, amt});
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        in_valid = 1'b0;
        while (!(busy === 1'b0 && fifo_count === '0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!(busy === 1'b0 && fifo_count === '0)) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b fifo_count=%0d expected 0/0", busy, fifo_count);
        end
    endtask

    task automatic do_reset;
        HRESET = 1'b1;
        in_valid = 1'b0;
        man_done = 1'b0;
        resp_delay = 0;
        exp_q.delete();
        @(negedge clk);
        HRESET = 1'b0;
        n_order = 0;
        n_max = 0;
    endtask

    initial begin
        int w;
        repeat (2) @(negedge clk);
        HRESET = 1'b0;
        mon_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_new_order", 32'(new_order), 32'd0);
        check("rst_new_max", 32'(new_max), 32'd0);
        check("rst_client_id", 32'(client_id), 32'd0);
        check("rst_amount", 32'(amount), 32'd0);
        check("rst_accept", 32'(accept_cnt), 32'd0);
        check("rst_reject", 32'(reject_cnt), 32'd0);
        check("rst_timeout", 32'(timeout_cnt), 32'd0);

        // Single accepted order, answered on WAIT cycle 2.
        resp_delay = 2;
        resp_ok = 1'b1;
        push_req(5'd3, 16'd100, 1'b0, w);
        wait_idle(100);
        check("t1_order_pulses", 32'(n_order), 32'd1);
        check("t1_max_pulses", 32'(n_max), 32'd0);
        check("t1_accept", 32'(accept_cnt), 32'd1);
        check("t1_reject", 32'(reject_cnt), 32'd0);
        check("t1_fifo_count", 32'(fifo_count), 32'd0);
        check("t1_wait_len", 32'(last_wait), 32'd2);

        // Max update with risk_ok=0 leaves order statistics alone.
        do_reset;
        resp_delay = 1;
        resp_ok = 1'b0;
        push_req(5'd5, 16'd500, 1'b1, w);
        wait_idle(100);
        check("t2_max_pulses", 32'(n_max), 32'd1);
        check("t2_order_pulses", 32'(n_order), 32'd0);
        check("t2_accept", 32'(accept_cnt), 32'd0);
        check("t2_reject", 32'(reject_cnt), 32'd0);
        check("t2_timeout", 32'(timeout_cnt), 32'd0);

        // Nine back-to-back requests, never answered: fill, backpressure, timeouts.
        do_reset;
        resp_delay = 0;
        resp_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_req(5'(i + 1), 16'(200 + i), 1'b0, w);
        end
        check("t3_ready_after_8", 32'(in_ready), 32'd0);
        check("t3_count_8", 32'(fifo_count), 32'd8);
        push_req(5'd9, 16'd208, 1'b1, w);
        in_valid = 1'b0;
        check("t3_ninth_wait", 32'(w), 32'd10);
        check("t3_timeout_at_ninth", 32'(timeout_cnt), 32'd1);
        wait_idle(400);
        check("t3_timeout", 32'(timeout_cnt), 32'd9);
        check("t3_accept", 32'(accept_cnt), 32'd0);
        check("t3_reject", 32'(reject_cnt), 32'd0);
        check("t3_wait_len", 32'(last_wait), 32'd15);

        // Timeout boundary: done on WAIT cycle 15, then no done at all.
        do_reset;
        resp_delay = 15;
        push_req(5'd7, 16'd700, 1'b0, w);
        wait_idle(100);
        check("t4_done15_accept", 32'(accept_cnt), 32'd1);
        check("t4_done15_timeout", 32'(timeout_cnt), 32'd0);
        check("t4_done15_len", 32'(last_wait), 32'd15);
        resp_delay = 0;
        push_req(5'd8, 16'd800, 1'b0, w);
        wait_idle(100);
        check("t4_to_timeout", 32'(timeout_cnt), 32'd1);
        check("t4_to_accept", 32'(accept_cnt), 32'd1);
        check("t4_to_len", 32'(last_wait), 32'd15);

        // Simultaneous push and pop at count 4, then 20 more through the wrap.
        do_reset;
        resp_delay = 0;
        resp_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(5'(10 + i), 16'(300 + i), 1'b0, w);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_count_before", 32'(fifo_count), 32'd4);
        check("t5_busy_before", 32'(busy), 32'd1);
        man_done = 1'b1;
        push_req(5'd14, 16'd304, 1'b0, w);
        man_done = 1'b0;
        in_valid = 1'b0;
        check("t5_count_after", 32'(fifo_count), 32'd4);
        check("t5_accept_after", 32'(accept_cnt), 32'd1);
        resp_delay = 1;
        for (int i = 0; i < 20; i++) begin
            push_req(5'(i), 16'(1000 + i), (i % 5 == 4), w);
        end
        wait_idle(600);
        check("t5_accept", 32'(accept_cnt), 32'd21);
        check("t5_reject", 32'(reject_cnt), 32'd0);
        check("t5_timeout", 32'(timeout_cnt), 32'd0);
        check("t5_all_issued", 32'(exp_q.size()), 32'd0);
        check("t5_pulses", 32'(n_order + n_max), 32'd25);

        // Reset while a request waits with three entries buffered.
        resp_delay = 0;
        for (int i = 0; i < 3; i++) begin
            push_req(5'(20 + i), 16'(900 + i), 1'b0, w);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_count_before", 32'(fifo_count), 32'd3);
        check("t6_busy_before", 32'(busy), 32'd1);
        do_reset;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_fifo_count", 32'(fifo_count), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_accept", 32'(accept_cnt), 32'd0);
        check("t6_reject", 32'(reject_cnt), 32'd0);
        check("t6_timeout", 32'(timeout_cnt), 32'd0);
        check("t6_new_order", 32'(new_order), 32'd0);
        repeat (20) @(negedge clk);
        check("t6_no_order_after", 32'(n_order), 32'd0);
        check("t6_no_max_after", 32'(n_max), 32'd0);
        check("t6_idle_after", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
